// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a single-port, one-cycle-latency
// word memory.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   MemRead, MemWrite           load / store request (store wins)
//   mem_size, mem_unsigned      00 byte, 01 half, 10 word; zero-extend
//   addr, wdata                 byte address, right-aligned store data
//   rdata, rdata_valid          extended load result
//   stall, misaligned           pipeline hold, request rejected
//   mem_re, mem_we, mem_addr,
//   mem_wdata, mem_rdata        data_memory side
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  rdata_valid,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD_WAIT = 2'd1;
    localparam logic [1:0] RMW_WAIT  = 2'd2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic [1:0]            state, nxt;
    logic [1:0]            lane_q, size_q;
    logic                  uns_q;
    logic [15:0]           wdata_q;
    logic [ADDR_WIDTH-1:0] idx_q;

    logic [ADDR_WIDTH-1:0] idx;
    logic                  req, mis, capture;
    logic [31:0]           shifted, ext, merged;

    logic [31:0]           rdata_c, wdata_c;
    logic                  valid_c, stall_c, mis_c, re_c, we_c;
    logic [ADDR_WIDTH-1:0] addr_c;

    logic unused_bits;
    assign unused_bits = ^{addr[31:ADDR_WIDTH+2], wdata[31:16]};

    assign idx = addr[ADDR_WIDTH+1:2];
    assign req = MemRead | MemWrite;
    assign mis = (mem_size == 2'b11)
               | ((mem_size == SZ_H) & addr[0])
               | ((mem_size == SZ_W) & (addr[1:0] != 2'b00));

    // Load lane extraction: move the addressed lane to bit 0.
    assign shifted = mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        ext = mem_rdata;
        unique case (size_q)
            SZ_B: ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            SZ_H: ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: ext = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (size_q == SZ_B) begin
            unique case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_comb begin
        nxt     = state;
        rdata_c = '0;
        valid_c = 1'b0;
        stall_c = 1'b0;
        mis_c   = 1'b0;
        re_c    = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        unique case (state)
            IDLE: begin
                if (req && mis) begin
                    mis_c = 1'b1;
                end else if (MemWrite && mem_size == SZ_W) begin
                    we_c    = 1'b1;
                    addr_c  = idx;
                    wdata_c = wdata;
                end else if (MemWrite) begin
                    re_c    = 1'b1;
                    addr_c  = idx;
                    stall_c = 1'b1;
                    nxt     = RMW_WAIT;
                end else if (MemRead) begin
                    re_c    = 1'b1;
                    addr_c  = idx;
                    stall_c = 1'b1;
                    nxt     = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                rdata_c = ext;
                valid_c = 1'b1;
                nxt     = IDLE;
            end
            RMW_WAIT: begin
                we_c    = 1'b1;
                addr_c  = idx_q;
                wdata_c = merged;
                nxt     = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign capture = (state == IDLE) && (nxt != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lane_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
        end else begin
            state <= nxt;
            if (capture) begin
                lane_q  <= addr[1:0];
                size_q  <= mem_size;
                uns_q   <= mem_unsigned;
                wdata_q <= wdata[15:0];
                idx_q   <= idx;
            end
        end
    end

    // Reset forces every output low at once, so a write pending in
    // RMW_WAIT is dropped before the clock edge.
    assign rdata       = rst_n ? rdata_c : '0;
    assign rdata_valid = rst_n & valid_c;
    assign stall       = rst_n & stall_c;
    assign misaligned  = rst_n & mis_c;
    assign mem_re      = rst_n & re_c;
    assign mem_we      = rst_n & we_c;
    assign mem_addr    = rst_n ? addr_c : '0;
    assign mem_wdata   = rst_n ? wdata_c : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic
// checked against a word-array reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata, rdata;
    logic        rdata_valid, stall, misaligned, mem_re, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:15];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .addr(addr), .wdata(wdata),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .stall(stall), .misaligned(misaligned),
        .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // data_memory: synchronous read, one-cycle latency
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a,
                                             input logic [1:0] sz,
                                             input logic un);
        logic [31:0] w, v;
        w = ref_mem[a[5:2]];
        if (sz == 2'd0) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (!un && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (!un && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] wd);
        logic [31:0] m, d;
        if (sz == 2'd2) begin
            ref_mem[a[5:2]] = wd;
        end else begin
            if (sz == 2'd0) begin
                m = 32'hFF << (8 * a[1:0]);
                d = (wd & 32'hFF) << (8 * a[1:0]);
            end else begin
                m = 32'hFFFF << (16 * a[1]);
                d = (wd & 32'hFFFF) << (16 * a[1]);
            end
            ref_mem[a[5:2]] = (ref_mem[a[5:2]] & ~m) | d;
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic un, input logic [31:0] a,
                       input logic [31:0] wd);
        logic bad_al;
        logic [31:0] e;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; mem_size = sz;
        mem_unsigned = un; addr = a; wdata = wd;
        #1;
        bad_al = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
                 (sz == 2'd2 && a[1:0] != 2'd0);
        if (!(rd || wr)) begin
            chk("idle_out", {stall, misaligned, mem_re, mem_we, rdata_valid},
                32'd0);
        end else if (bad_al) begin
            chk("mis_flag", {31'd0, misaligned}, 32'd1);
            chk("mis_side", {stall, mem_re, mem_we}, 32'd0);
        end else if (wr && sz == 2'd2) begin
            chk("sw_ctl", {stall, mem_re, mem_we}, 32'b001);
            chk("sw_addr", {24'd0, mem_addr}, {24'd0, a[9:2]});
            chk("sw_data", mem_wdata, wd);
            ref_store(a, sz, wd);
        end else if (wr) begin
            chk("rmw_c1", {stall, mem_re, mem_we}, 32'b110);
            @(negedge clk); #1;
            chk("rmw_c2", {stall, mem_re, mem_we}, 32'b001);
            chk("rmw_addr", {24'd0, mem_addr}, {24'd0, a[9:2]});
            ref_store(a, sz, wd);
        end else begin
            e = ref_load(a, sz, un);
            chk("ld_c1", {stall, mem_re, rdata_valid}, 32'b110);
            chk("ld_addr", {24'd0, mem_addr}, {24'd0, a[9:2]});
            @(negedge clk); #1;
            chk("ld_c2", {stall, rdata_valid}, 32'b01);
            chk("ld_data", rdata, e);
        end
    endtask

    task automatic idle_in;
        @(negedge clk);
        MemRead = 0; MemWrite = 0; mem_size = 0;
        mem_unsigned = 0; addr = 0; wdata = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] op;
        logic [31:0] v;
        rst_n = 0; MemRead = 0; MemWrite = 0; mem_size = 0;
        mem_unsigned = 0; addr = 0; wdata = 0;
        pl_en = 1; pl_addr = 0; pl_data = 0;
        #1;
        chk("rst_out", {stall, misaligned, mem_re, mem_we, rdata_valid},
            32'd0);
        chk("rst_rdata", rdata, 32'd0);
        for (int i = 0; i < 16; i++) begin
            v = (i == 3) ? 32'h8899AABB : $urandom;
            ref_mem[i] = v;
            @(negedge clk);
            pl_addr = 8'(i); pl_data = v;
        end
        @(negedge clk);
        pl_en = 0; rst_n = 1;

        req(1, 0, 2'd2, 0, 32'h0C, 0);
        chk("lw_w3", rdata, 32'h8899AABB);
        req(1, 0, 2'd0, 0, 32'h0D, 0);
        chk("lb", rdata, 32'hFFFFFFAA);
        req(1, 0, 2'd0, 1, 32'h0D, 0);
        chk("lbu", rdata, 32'h000000AA);
        req(1, 0, 2'd1, 0, 32'h0E, 0);
        chk("lh", rdata, 32'hFFFF8899);
        req(1, 0, 2'd1, 1, 32'h0E, 0);
        chk("lhu", rdata, 32'h00008899);
        req(0, 1, 2'd0, 0, 32'h0E, 32'h12345677);
        idle_in();
        chk("sb_mem", mem[3], 32'h8877AABB);
        req(0, 1, 2'd1, 0, 32'h0C, 32'h0000CAFE);
        idle_in();
        chk("sh_mem", mem[3], 32'h8877CAFE);
        req(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        req(1, 0, 2'd2, 0, 32'h10, 0);
        chk("sw_lw", rdata, 32'hDEADBEEF);
        req(1, 0, 2'd2, 0, 32'h0E, 0);
        req(0, 1, 2'd1, 0, 32'h0D, 32'hFFFF);
        idle_in();
        chk("mis_mem", mem[3], 32'h8877CAFE);

        // reset while the sub-word write is pending
        req(0, 0, 2'd0, 0, 0, 0);
        @(negedge clk);
        MemWrite = 1; mem_size = 2'd0; addr = 32'h0C; wdata = 32'h55;
        #1;
        chk("rst_c1", {31'd0, stall}, 32'd1);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst_mid", {stall, misaligned, mem_re, mem_we, rdata_valid},
            32'd0);
        chk("rst_wd", mem_wdata, 32'd0);
        @(negedge clk);
        MemWrite = 0; mem_size = 0; addr = 0; wdata = 0;
        rst_n = 1;
        #1;
        chk("rst_mem", mem[3], 32'h8877CAFE);
        req(1, 0, 2'd2, 0, 32'h0C, 0);
        chk("rst_lw", rdata, 32'h8877CAFE);

        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            req(op[0], op[1], 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
                $urandom);
        end
        idle_in();
        idle_in();
        for (int i = 0; i < 16; i++) chk("end_mem", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store initiator that drives `data_memory` (single-port, synchronous read with one-cycle latency, word-addressed) on behalf of the pipeline. It converts byte addresses and access sizes (`lb/lbu/lh/lhu/lw/sb/sh/sw`) into word accesses, performs sign/zero extension on loads, and does read-modify-write for sub-word stores. It asserts `stall` to freeze the pipeline while a memory round-trip is outstanding.

## Interface
- `DATA_WIDTH`, 32, memory word width; only 32 is supported.
- `ADDR_WIDTH`, 8, memory word-address width; 256 words.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `MemRead` in 1: load request from MEM stage.
- `MemWrite` in 1: store request; wins if both are high, and `MemRead` is then ignored.
- `mem_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `mem_unsigned` in 1: zero-extend loads when 1.
- `addr` in 32: byte address; word index = `addr[ADDR_WIDTH+1:2]`, lane = `addr[1:0]`.
- `wdata` in 32: store data, right-aligned.
- `rdata` out 32: extended load result; 0 when `rdata_valid`=0.
- `rdata_valid` out 1: load result valid this cycle.
- `stall` out 1: pipeline must hold the MEM stage and all request inputs stable.
- `misaligned` out 1: request rejected this cycle.
- `mem_re`, `mem_we` out 1: to `data_memory` MemRead/MemWrite.
- `mem_addr` out ADDR_WIDTH: to `data_memory` address.
- `mem_wdata` out 32: to `data_memory` write_data.
- `mem_rdata` in 32: from `data_memory` read_data.

## Operation
- Lanes are little-endian: byte k = bits [8k+7:8k]; the half at `addr[1]`=0 is [15:0], and at `addr[1]`=1 is [31:16].
- A request is misaligned if it is a half with `addr[0]`=1, a word with `addr[1:0]`≠0, or uses size 11.
- FSM states: IDLE, LOAD_WAIT, RMW_WAIT.
- **IDLE**
  - No request: all memory outputs are 0.
  - Misaligned request: `misaligned`=1 (combinational), no `mem_re`/`mem_we`, `stall`=0, stay in IDLE.
  - Load: `mem_re`=1 and `mem_addr`=word index. Capture lane, size, unsigned, and word index. `stall`=1. Go to LOAD_WAIT.
  - Store word: `mem_we`=1, `mem_wdata`=`wdata`, `stall`=0, stay in IDLE.
  - Store byte/half: `mem_re`=1. Capture lane, size, `wdata`, and word index. `stall`=1. Go to RMW_WAIT.
- **LOAD_WAIT**
  - Extract the captured lane from `mem_rdata` and sign- or zero-extend it to 32 bits.
  - Drive `rdata` with the result and `rdata_valid`=1, with `stall`=0.
  - Go to IDLE. Request inputs, which are still asserted this cycle for the same instruction, are ignored.
- **RMW_WAIT**
  - `mem_wdata` = `mem_rdata` with the captured lane replaced by `wdata[7:0]` or `wdata[15:0]`.
  - `mem_we`=1, `mem_addr`=captured index, `stall`=0.
  - Go to IDLE. Inputs are ignored.
- In the wait states, memory-side outputs come from captured registers, not from live inputs.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE, all captured registers 0, all outputs 0. This takes effect immediately, including mid-operation. A reset during RMW_WAIT drops `mem_we` before the edge, so memory is left unchanged.
- Load: 2 cycles, 1 stall cycle. Data is valid in the second cycle.
- Word store: 1 cycle, no stall. The write commits at the end of the request cycle.
- Sub-word store: 2 cycles, 1 stall cycle. The write commits at the end of the second cycle.
- Back-to-back requests: a new request is accepted in the cycle after LOAD_WAIT or RMW_WAIT. A load immediately after any store reads the updated word.
- `stall` and `misaligned` are combinational from the inputs in IDLE only.

## Test plan
- Preload word 3 = 0x8899AABB. `lw` at addr 0x0C produces `stall`=1 for 1 cycle, then `rdata`=0x8899AABB with `rdata_valid`=1.
- Extension on word 3:
  - `lb` 0x0D gives 0xFFFFFFAA; `lbu` 0x0D gives 0x000000AA.
  - `lh` 0x0E gives 0xFFFF8899; `lhu` 0x0E gives 0x00008899.
- `sb` at 0x0E with `wdata`=0x12345677: 1 stall cycle, `mem_we` in the second cycle, word 3 becomes 0x8877AABB. A following `sh` at 0x0C with `wdata`=0x0000CAFE gives 0x8877CAFE.
- `sw` at 0x10 with 0xDEADBEEF: no stall and `mem_we` in the same cycle. A back-to-back `lw` at 0x10 then returns 0xDEADBEEF.
- Misalignment: `lw` at 0x0E and `sh` at 0x0D each give `misaligned`=1 for one cycle, `stall`=0, and no `mem_re`/`mem_we`. Memory is unchanged.
- Reset mid-operation: assert `rst_n`=0 in RMW_WAIT of `sb` 0x0C. Result: `mem_we`=0, word unchanged, FSM in IDLE, all outputs 0. A subsequent `lw` works normally.
